// File: rtl/reg_spill_engine.sv
// reg_spill_engine: walks the register file and moves every register except
// the hard-zero register to data memory (spill) or back from it (restore).
// While busy it owns the register-file rs1 read port and the write port.
// Build option: define SPILL_CHECKSUM_EN to build the XOR checksum
// accumulator; without it the checksum output is tied to zero.
module reg_spill_engine #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ZERO_REG = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spill_start,
    input  logic        restore_start,
    input  logic [31:0] base_addr,
    input  logic        bank_sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum,
    output logic        uCodeFlag,
    output logic [3:0]  rf_rs1,
    input  logic [31:0] rf_rs1_data,
    output logic [3:0]  rf_rd,
    output logic        rf_write,
    output logic [31:0] rf_writeData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPILL = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Walk bounds: skip the zero register even if it sits at either end.
    localparam logic [3:0] ZERO_IDX  = 4'(ZERO_REG);
    localparam logic [3:0] FIRST_IDX = (ZERO_REG == 32'd0) ? 4'd1 : 4'd0;
    localparam logic [3:0] LAST_IDX  = (ZERO_REG == NUM_REGS - 32'd1) ?
                                       4'(NUM_REGS - 32'd2) : 4'(NUM_REGS - 32'd1);

    state_t      state_r, state_s;
    logic [3:0]  idx_r, idx_s;
    logic [31:0] base_r, base_s;
    logic        bank_r, bank_s;
    logic [31:0] data_r, data_s;
    logic [31:0] addr_s;
`ifdef SPILL_CHECKSUM_EN
    logic [31:0] csum_r, csum_s;
`endif

    // Next register index, hopping over the hard-zero register.
    function automatic logic [3:0] next_idx(input logic [3:0] cur);
        logic [3:0] inc;
        inc = cur + 4'd1;
        if (inc == ZERO_IDX) begin
            next_idx = cur + 4'd2;
        end else begin
            next_idx = inc;
        end
    endfunction

    assign addr_s = base_r + {26'd0, idx_r, 2'b00};

    // Next-state, latch capture and per-state output decode.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        base_s       = base_r;
        bank_s       = bank_r;
        data_s       = data_r;
`ifdef SPILL_CHECKSUM_EN
        csum_s       = csum_r;
`endif
        busy         = 1'b0;
        done         = 1'b0;
        checksum     = 32'd0;
        uCodeFlag    = 1'b0;
        rf_rs1       = 4'd0;
        rf_rd        = 4'd0;
        rf_write     = 1'b0;
        rf_writeData = 32'd0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (spill_start || restore_start) begin
                    // Spill has priority when both requests arrive together.
                    state_s = spill_start ? ST_SPILL : ST_LOAD;
                    idx_s   = FIRST_IDX;
                    base_s  = base_addr & 32'hFFFF_FFFC;
                    bank_s  = bank_sel;
`ifdef SPILL_CHECKSUM_EN
                    csum_s  = 32'd0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SPILL: begin
                busy      = 1'b1;
                uCodeFlag = bank_r;
                rf_rs1    = idx_r;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_s;
                mem_wdata = rf_rs1_data;
                if (mem_ready) begin
`ifdef SPILL_CHECKSUM_EN
                    csum_s = csum_r ^ rf_rs1_data;
`endif
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_DONE;
                    end else begin
                        idx_s = next_idx(idx_r);
                    end
                end else begin
                    state_s = ST_SPILL;
                end
            end
            ST_LOAD: begin
                busy      = 1'b1;
                uCodeFlag = bank_r;
                mem_req   = 1'b1;
                mem_addr  = addr_s;
                if (mem_ready) begin
                    data_s  = mem_rdata;
                    state_s = ST_WB;
`ifdef SPILL_CHECKSUM_EN
                    csum_s  = csum_r ^ mem_rdata;
`endif
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_WB: begin
                busy         = 1'b1;
                uCodeFlag    = bank_r;
                rf_write     = 1'b1;
                rf_rd        = idx_r;
                rf_writeData = data_r;
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s   = next_idx(idx_r);
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                uCodeFlag = bank_r;
`ifdef SPILL_CHECKSUM_EN
                checksum  = csum_r;
`endif
                idx_s     = 4'd0;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 4'd0;
            end
        endcase
    end

    // State, index and start-time latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
            base_r  <= 32'd0;
            bank_r  <= 1'b0;
            data_r  <= 32'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            base_r  <= base_s;
            bank_r  <= bank_s;
            data_r  <= data_s;
        end
    end

`ifdef SPILL_CHECKSUM_EN
    // Running XOR of every word moved in the current operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_r <= 32'd0;
        end else begin
            csum_r <= csum_s;
        end
    end
`endif

endmodule

// File: tb/tb_reg_spill_engine.sv
// Scoreboard bench for reg_spill_engine: a driver issues operations and
// pushes the expected memory transfers, register writes and completion into
// queues; an independent monitor pops and compares as the DUT presents them.
module tb_reg_spill_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spill_start = 1'b0;
    logic        restore_start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        bank_sel = 1'b0;
    logic        busy, done, uCodeFlag, rf_write, mem_req, mem_we, mem_ready;
    logic [31:0] checksum, rf_writeData, mem_addr, mem_wdata, rf_rs1_data, mem_rdata;
    logic [3:0]  rf_rs1, rf_rd;

`ifdef SPILL_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_spill_engine dut (
        .clk(clk), .rst(rst),
        .spill_start(spill_start), .restore_start(restore_start),
        .base_addr(base_addr), .bank_sel(bank_sel),
        .busy(busy), .done(done), .checksum(checksum), .uCodeFlag(uCodeFlag),
        .rf_rs1(rf_rs1), .rf_rs1_data(rf_rs1_data),
        .rf_rd(rf_rd), .rf_write(rf_write), .rf_writeData(rf_writeData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Environment: register file, memory responder with scripted wait states.
    logic [31:0] rf [16];
    logic [31:0] preset_vals [16];
    logic        preset_go = 1'b0;
    int          wait_arr [32];
    int          wcnt = 0;
    int          xk = 0;
    int          cyc = 0;
    logic [31:0] load_salt = 32'd0;

    assign rf_rs1_data = rf[rf_rs1];
    assign mem_rdata   = (32'hA000_0000 | mem_addr) ^ load_salt;
    assign mem_ready   = mem_req && (wcnt >= wait_arr[xk]);

    // Cycle counter, register-file writes and wait-state sequencing.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preset_go) begin
            rf <= preset_vals;
        end else if (rf_write) begin
            rf[rf_rd] <= rf_writeData;
        end
        if (!busy) begin
            wcnt <= 0;
            xk   <= 0;
        end else if (mem_req && mem_ready) begin
            wcnt <= 0;
            xk   <= xk + 1;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic flag; } xfer_t;
    typedef struct packed { logic [3:0] rd; logic [31:0] data; logic flag; } wb_t;
    typedef struct packed { logic [31:0] cyc; logic [31:0] csum; logic flag; } done_t;

    xfer_t       st_q [$];
    xfer_t       ld_q [$];
    wb_t         wb_q [$];
    done_t       dn_q [$];
    logic [31:0] ref_rf [16];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          chk_req = 0;
    int          chk_seen = 0;

    // Monitor: compares every DUT-presented event with the scoreboard.
    initial begin : monitor
        xfer_t       ex;
        wb_t         ew;
        done_t       ed;
        logic        prev_wait;
        logic        prev_we;
        logic [31:0] prev_addr, prev_wdata;
        prev_wait = 1'b0; prev_we = 1'b0; prev_addr = 32'd0; prev_wdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                tests++;
                if ({busy, done, uCodeFlag, rf_write, mem_req, mem_we, rf_rs1, rf_rd} !== 10'd0 ||
                    checksum !== 32'd0 || rf_writeData !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
                    fails++;
                    $display("FAIL reset_outputs: busy=%b done=%b flag=%b rfw=%b req=%b we=%b rs1=%h rd=%h csum=%h wd=%h addr=%h md=%h, expected all 0",
                             busy, done, uCodeFlag, rf_write, mem_req, mem_we, rf_rs1, rf_rd, checksum, rf_writeData, mem_addr, mem_wdata);
                end
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) begin
                    tests++;
                    if (mem_req !== 1'b1 || mem_we !== prev_we || mem_addr !== prev_addr || mem_wdata !== prev_wdata) begin
                        fails++;
                        $display("FAIL wait_hold: req=%b we=%b addr=%h wdata=%h, expected req=1 we=%b addr=%h wdata=%h",
                                 mem_req, mem_we, mem_addr, mem_wdata, prev_we, prev_addr, prev_wdata);
                    end
                end
                if (mem_req && mem_ready) begin
                    tests++;
                    if (mem_we) begin
                        if (st_q.size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_store: addr=%h data=%h, expected no store", mem_addr, mem_wdata);
                        end else begin
                            ex = st_q.pop_front();
                            if (mem_addr !== ex.addr || mem_wdata !== ex.data || uCodeFlag !== ex.flag) begin
                                fails++;
                                $display("FAIL store: addr=%h data=%h flag=%b, expected addr=%h data=%h flag=%b",
                                         mem_addr, mem_wdata, uCodeFlag, ex.addr, ex.data, ex.flag);
                            end
                        end
                    end else begin
                        if (ld_q.size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_load: addr=%h, expected no load", mem_addr);
                        end else begin
                            ex = ld_q.pop_front();
                            if (mem_addr !== ex.addr || uCodeFlag !== ex.flag) begin
                                fails++;
                                $display("FAIL load: addr=%h flag=%b, expected addr=%h flag=%b",
                                         mem_addr, uCodeFlag, ex.addr, ex.flag);
                            end
                        end
                    end
                end
                if (rf_write) begin
                    tests++;
                    if (wb_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_rf_write: rd=%0d data=%h, expected no write", rf_rd, rf_writeData);
                    end else begin
                        ew = wb_q.pop_front();
                        if (rf_rd !== ew.rd || rf_writeData !== ew.data || uCodeFlag !== ew.flag) begin
                            fails++;
                            $display("FAIL rf_write: rd=%0d data=%h flag=%b, expected rd=%0d data=%h flag=%b",
                                     rf_rd, rf_writeData, uCodeFlag, ew.rd, ew.data, ew.flag);
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    tests++;
                    if (dn_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_done: cycle=%0d, expected no done", cyc);
                    end else begin
                        ed = dn_q.pop_front();
                        if (32'(cyc) !== ed.cyc || checksum !== ed.csum || uCodeFlag !== ed.flag) begin
                            fails++;
                            $display("FAIL done: cycle=%0d csum=%h flag=%b, expected cycle=%0d csum=%h flag=%b",
                                     cyc, checksum, uCodeFlag, ed.cyc, ed.csum, ed.flag);
                        end
                    end
                    tests++;
                    if (st_q.size() != 0 || ld_q.size() != 0 || wb_q.size() != 0) begin
                        fails++;
                        $display("FAIL done_drain: pending st=%0d ld=%0d wb=%0d, expected 0 0 0",
                                 st_q.size(), ld_q.size(), wb_q.size());
                    end
                end
                prev_wait  = mem_req && !mem_ready;
                prev_we    = mem_we;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
            end
            if (chk_req != chk_seen) begin
                chk_seen = chk_req;
                tests++;
                if (busy !== 1'b0 || st_q.size() != 0 || ld_q.size() != 0 || wb_q.size() != 0 || dn_q.size() != 0) begin
                    fails++;
                    $display("FAIL idle_check: busy=%b pending st=%0d ld=%0d wb=%0d dn=%0d, expected busy=0 and none pending",
                             busy, st_q.size(), ld_q.size(), wb_q.size(), dn_q.size());
                end
                for (int i = 0; i < 16; i++) begin
                    tests++;
                    if (rf[i] !== ref_rf[i]) begin
                        fails++;
                        $display("FAIL rf_contents: R%0d=%h, expected %h", i, rf[i], ref_rf[i]);
                    end
                end
            end
        end
    end

    // Issue one complete spill or restore and wait for its completion.
    task automatic run_op(input bit spill, input bit both, input logic [31:0] base,
                          input bit bank, input int wmax, input bit wrand, input bit pulse_busy);
        logic [31:0] b, a, w, csum;
        int          lat, n, seen, k;
        done_t       d;
        b = {base[31:2], 2'b00};
        csum = 32'd0;
        lat = 1;
        k = 0;
        for (int j = 0; j < 32; j++) wait_arr[j] = wrand ? int'($urandom_range(0, wmax)) : wmax;
        for (int i = 0; i < 16; i++) begin
            if (i == 14) continue;
            a = b + 32'(4 * i);
            if (spill || both) begin
                st_q.push_back('{addr: a, data: ref_rf[i], flag: bank});
                csum = csum ^ ref_rf[i];
                lat  = lat + 1 + wait_arr[k];
            end else begin
                w = (32'hA000_0000 | a) ^ load_salt;
                ld_q.push_back('{addr: a, data: w, flag: bank});
                wb_q.push_back('{rd: 4'(i), data: w, flag: bank});
                ref_rf[i] = w;
                csum = csum ^ w;
                lat  = lat + 2 + wait_arr[k];
            end
            k++;
        end
        spill_start   = spill || both;
        restore_start = !spill || both;
        base_addr     = base;
        bank_sel      = bank;
        @(posedge clk); #1;
        n = cyc;
        d = '{cyc: 32'(n + lat - 1), csum: (CSUM_EN ? csum : 32'd0), flag: bank};
        dn_q.push_back(d);
        spill_start   = 1'b0;
        restore_start = 1'b0;
        base_addr     = $urandom;
        bank_sel      = 1'($urandom_range(0, 1));
        seen = done_cnt;
        for (int t = 0; t < 400 && done_cnt == seen; t++) begin
            restore_start = (pulse_busy && t == 3);
            @(posedge clk); #1;
        end
        restore_start = 1'b0;
        if (done_cnt == seen) begin
            $display("FAIL done_timeout: no done after 400 cycles, expected done at cycle %0d", d.cyc);
            $fatal(1, "done wait expired");
        end
    endtask

    // Restore that is aborted by reset during the fifth load (R4).
    task automatic reset_mid_restore(input logic [31:0] base, input bit bank);
        logic [31:0] b, a, w;
        b = {base[31:2], 2'b00};
        for (int j = 0; j < 32; j++) wait_arr[j] = 0;
        for (int i = 0; i < 4; i++) begin
            a = b + 32'(4 * i);
            w = (32'hA000_0000 | a) ^ load_salt;
            ld_q.push_back('{addr: a, data: w, flag: bank});
            wb_q.push_back('{rd: 4'(i), data: w, flag: bank});
            ref_rf[i] = w;
        end
        restore_start = 1'b1;
        base_addr     = base;
        bank_sel      = bank;
        @(posedge clk); #1;
        restore_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic final_check();
        chk_req++;
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Driver: test sequence.
    initial begin : driver
        for (int j = 0; j < 32; j++) wait_arr[j] = 0;
        for (int i = 0; i < 16; i++) begin
            preset_vals[i] = (i == 14) ? 32'd0 : 32'h100 + 32'(i);
            ref_rf[i]      = preset_vals[i];
        end
        preset_go = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preset_go = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(1'b1, 1'b0, 32'h0000_1000, 1'b0, 0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 32'h0000_1000, 1'b0, 2, 1'b0, 1'b0);
        load_salt = 32'd0;
        run_op(1'b0, 1'b0, 32'h0000_2000, 1'b1, 0, 1'b0, 1'b0);
        run_op(1'b1, 1'b1, 32'h0000_3000, 1'b0, 0, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 32'hFFFF_FFF0, 1'b1, 1, 1'b1, 1'b0);
        load_salt = 32'h0BAD_F00D;
        run_op(1'b0, 1'b0, 32'hFFFF_FFE3, 1'b0, 1, 1'b1, 1'b0);
        final_check();
        for (int r = 0; r < 8; r++) begin
            load_salt = $urandom;
            run_op(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'($urandom_range(0, 1)), 3, 1'b1, 1'b0);
        end
        final_check();
        load_salt = 32'h5A5A_0000;
        reset_mid_restore(32'h0000_4000, 1'b1);
        final_check();
        run_op(1'b1, 1'b0, 32'h0000_5000, 1'b0, 0, 1'b0, 1'b0);
        final_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
